// File: rtl/eth_frame_detector_pkg.sv
// Shared types and constants for the frame detector log path.
package eth_frame_detector_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPassA,
    StPassB,
    StDropA,
    StDropB
  } arb_state_e;

  localparam logic LOG_SRC_A = 1'b0;
  localparam logic LOG_SRC_B = 1'b1;

  function automatic int unsigned beat_cnt_w(input int unsigned max_beats);
    return (max_beats > 1) ? $clog2(max_beats) : 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Registered AXI4-Stream stage with one skid slot; in_ready_o is a flop output and
// never depends combinationally on out_ready_i.
module axis_skid_buffer #(
  parameter int unsigned DATA_W = 66
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i
);

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              skid_valid_q;
  logic [DATA_W-1:0] skid_data_q;
  logic              in_ready_q;
  logic              in_fire;
  logic              out_free;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_free = ~out_valid_q | out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else if (skid_valid_q) begin
      // Skid only fills while out is stalled, so out_valid_q stays 1 here.
      if (out_ready_i) begin
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
        in_ready_q   <= 1'b1;
      end
    end else if (in_fire) begin
      if (out_free) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_data_i;
      end else begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= in_data_i;
        in_ready_q   <= 1'b0;
      end
    end else begin
      in_ready_q <= 1'b1;
      if (out_ready_i) out_valid_q <= 1'b0;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/eth_frame_detector_log_arbiter.sv
// Frame-granular round-robin merge of log A and log B onto one tagged AXI4-Stream,
// with runaway-frame truncation and per-source frame statistics.
module eth_frame_detector_log_arbiter
  import eth_frame_detector_pkg::*;
#(
  parameter int unsigned C_AXIS_LOG_WIDTH  = 64,
  parameter int unsigned C_MAX_FRAME_BEATS = 64
) (
  input  logic                        s_axi_clk,
  input  logic                        s_axi_resetn,
  input  logic                        enable,
  input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_log_a_tdata,
  input  logic                        s_axis_log_a_tlast,
  input  logic                        s_axis_log_a_tvalid,
  output logic                        s_axis_log_a_tready,
  input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_log_b_tdata,
  input  logic                        s_axis_log_b_tlast,
  input  logic                        s_axis_log_b_tvalid,
  output logic                        s_axis_log_b_tready,
  output logic [C_AXIS_LOG_WIDTH-1:0] m_axis_log_tdata,
  output logic                        m_axis_log_tid,
  output logic                        m_axis_log_tlast,
  output logic                        m_axis_log_tvalid,
  input  logic                        m_axis_log_tready,
  output logic [31:0]                 frames_a,
  output logic [31:0]                 frames_b,
  output logic [15:0]                 trunc_a,
  output logic [15:0]                 trunc_b
);

  localparam int unsigned W        = C_AXIS_LOG_WIDTH;
  localparam int unsigned BeatCntW = beat_cnt_w(C_MAX_FRAME_BEATS);
  localparam logic [BeatCntW-1:0] LastBeat = BeatCntW'(C_MAX_FRAME_BEATS - 1);

  arb_state_e          state_q;
  logic                rr_b_q;
  logic [BeatCntW-1:0] beat_cnt_q;
  logic [31:0]         frames_a_q, frames_b_q;
  logic [15:0]         trunc_a_q, trunc_b_q;

  logic         skid_ready;
  logic         pass_a, pass_b, drop_a, drop_b;
  logic         sel_b, sel_last, trunc_now;
  logic         fwd_valid, fwd_fire;
  logic [W+1:0] fwd_word, out_word;
  logic         out_valid, out_fire;

  assign pass_a = (state_q == StPassA);
  assign pass_b = (state_q == StPassB);
  assign drop_a = (state_q == StDropA);
  assign drop_b = (state_q == StDropB);

  assign s_axis_log_a_tready = (pass_a & skid_ready) | drop_a;
  assign s_axis_log_b_tready = (pass_b & skid_ready) | drop_b;

  assign sel_b     = pass_b;
  assign sel_last  = sel_b ? s_axis_log_b_tlast : s_axis_log_a_tlast;
  assign trunc_now = ~sel_last & (beat_cnt_q == LastBeat);
  assign fwd_valid = (pass_a & s_axis_log_a_tvalid) | (pass_b & s_axis_log_b_tvalid);
  assign fwd_fire  = fwd_valid & skid_ready;
  // Source tag rides with the beat so it stays correct while the skid drains.
  assign fwd_word  = {sel_b ? LOG_SRC_B : LOG_SRC_A, sel_last | trunc_now,
                      sel_b ? s_axis_log_b_tdata : s_axis_log_a_tdata};

  axis_skid_buffer #(
    .DATA_W(W + 2)
  ) u_skid (
    .clk_i      (s_axi_clk),
    .rst_ni     (s_axi_resetn),
    .in_valid_i (fwd_valid),
    .in_data_i  (fwd_word),
    .in_ready_o (skid_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_word),
    .out_ready_i(m_axis_log_tready)
  );

  always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
    if (!s_axi_resetn) begin
      state_q    <= StIdle;
      rr_b_q     <= 1'b0;
      beat_cnt_q <= '0;
      trunc_a_q  <= '0;
      trunc_b_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            if (s_axis_log_a_tvalid && (!s_axis_log_b_tvalid || !rr_b_q)) state_q <= StPassA;
            else if (s_axis_log_b_tvalid) state_q <= StPassB;
          end
        end
        StPassA, StPassB: begin
          if (fwd_fire) begin
            if (sel_last) begin
              state_q    <= StIdle;
              rr_b_q     <= ~sel_b;
              beat_cnt_q <= '0;
            end else if (beat_cnt_q == LastBeat) begin
              state_q    <= sel_b ? StDropB : StDropA;
              beat_cnt_q <= '0;
              if (sel_b) begin
                if (trunc_b_q != 16'hFFFF) trunc_b_q <= trunc_b_q + 16'd1;
              end else begin
                if (trunc_a_q != 16'hFFFF) trunc_a_q <= trunc_a_q + 16'd1;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + BeatCntW'(1);
            end
          end
        end
        StDropA: begin
          if (s_axis_log_a_tvalid && s_axis_log_a_tlast) begin
            state_q <= StIdle;
            rr_b_q  <= 1'b1;
          end
        end
        StDropB: begin
          if (s_axis_log_b_tvalid && s_axis_log_b_tlast) begin
            state_q <= StIdle;
            rr_b_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_fire = out_valid & m_axis_log_tready;

  always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
    if (!s_axi_resetn) begin
      frames_a_q <= '0;
      frames_b_q <= '0;
    end else if (out_fire && out_word[W]) begin
      if (out_word[W+1]) frames_b_q <= frames_b_q + 32'd1;
      else               frames_a_q <= frames_a_q + 32'd1;
    end
  end

  assign m_axis_log_tdata  = out_word[W-1:0];
  assign m_axis_log_tlast  = out_word[W];
  assign m_axis_log_tid    = out_word[W+1];
  assign m_axis_log_tvalid = out_valid;
  assign frames_a          = frames_a_q;
  assign frames_b          = frames_b_q;
  assign trunc_a           = trunc_a_q;
  assign trunc_b           = trunc_b_q;

endmodule

// File: tb/tb_eth_frame_detector_log_arbiter.sv
// Randomized bench for the log arbiter: per-source frame scoreboard plus directed scenarios.
module tb_eth_frame_detector_log_arbiter;

  localparam int unsigned W        = 64;
  localparam int unsigned MaxBeats = 4;

  logic          clk, rst_n, enable;
  logic [W-1:0]  a_tdata, b_tdata, m_tdata;
  logic          a_tlast, a_tvalid, a_tready;
  logic          b_tlast, b_tvalid, b_tready;
  logic          m_tid, m_tlast, m_tvalid, m_tready;
  logic [31:0]   frames_a, frames_b;
  logic [15:0]   trunc_a, trunc_b;

  logic [64:0] src_a[$], src_b[$], exp_a[$], exp_b[$];
  bit          tid_log[$];
  int          hs_cyc[$];
  int          tot_fr[2], tot_tr[2];
  int          gap_pct, cyc, n_checks, n_errors;
  bit          rand_ready, seen;

  eth_frame_detector_log_arbiter #(
    .C_AXIS_LOG_WIDTH (W),
    .C_MAX_FRAME_BEATS(MaxBeats)
  ) dut (
    .s_axi_clk          (clk),
    .s_axi_resetn       (rst_n),
    .enable             (enable),
    .s_axis_log_a_tdata (a_tdata),
    .s_axis_log_a_tlast (a_tlast),
    .s_axis_log_a_tvalid(a_tvalid),
    .s_axis_log_a_tready(a_tready),
    .s_axis_log_b_tdata (b_tdata),
    .s_axis_log_b_tlast (b_tlast),
    .s_axis_log_b_tvalid(b_tvalid),
    .s_axis_log_b_tready(b_tready),
    .m_axis_log_tdata   (m_tdata),
    .m_axis_log_tid     (m_tid),
    .m_axis_log_tlast   (m_tlast),
    .m_axis_log_tvalid  (m_tvalid),
    .m_axis_log_tready  (m_tready),
    .frames_a           (frames_a),
    .frames_b           (frames_b),
    .trunc_a            (trunc_a),
    .trunc_b            (trunc_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected output of a frame: first MaxBeats beats, tlast forced on the last one kept.
  task automatic push_frame(input bit s, input int len);
    logic [64:0] w;
    for (int i = 0; i < len; i++) begin
      w = {(i == len - 1), $urandom, $urandom};
      if (s) src_b.push_back(w);
      else   src_a.push_back(w);
      if (i < int'(MaxBeats)) begin
        w[64] = (i == len - 1) || (i == int'(MaxBeats) - 1);
        if (s) exp_b.push_back(w);
        else   exp_a.push_back(w);
      end
    end
    tot_fr[s]++;
    if (len > int'(MaxBeats)) tot_tr[s]++;
  endtask

  task automatic drive(input bit s);
    logic        fire, hold, vld;
    logic [64:0] w;
    forever begin
      @(negedge clk);
      fire = s ? (b_tvalid && b_tready) : (a_tvalid && a_tready);
      @(posedge clk);
      #1;
      if (fire) begin
        if (s && src_b.size() > 0)  w = src_b.pop_front();
        if (!s && src_a.size() > 0) w = src_a.pop_front();
      end
      hold = (s ? b_tvalid : a_tvalid) && !fire && rst_n;
      if (!hold) begin
        vld = rst_n && ((s ? src_b.size() : src_a.size()) > 0) &&
              ($urandom_range(0, 99) >= gap_pct);
        if (s) begin
          b_tvalid = vld;
          if (vld) {b_tlast, b_tdata} = src_b[0];
        end else begin
          a_tvalid = vld;
          if (vld) {a_tlast, a_tdata} = src_a[0];
        end
      end
    end
  endtask

  initial drive(1'b0);
  initial drive(1'b1);

  initial forever begin
    @(posedge clk);
    #1;
    m_tready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  initial begin
    logic        stall, in_frame, cur_tid;
    logic [65:0] stall_word;
    logic [64:0] w;
    stall = 1'b0;
    in_frame = 1'b0;
    cur_tid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        in_frame = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", 66'(m_tvalid), 66'(1));
          check("hold_word", {m_tid, m_tlast, m_tdata}, stall_word);
        end
        if (m_tvalid && m_tready) begin
          hs_cyc.push_back(cyc);
          if ((m_tid ? exp_b.size() : exp_a.size()) == 0) begin
            check("extra_beat", 66'(m_tvalid), 66'(0));
          end else begin
            if (m_tid) w = exp_b.pop_front();
            else       w = exp_a.pop_front();
            check("beat", {1'b0, m_tlast, m_tdata}, {1'b0, w});
          end
          if (in_frame) check("interleave", 66'(m_tid), 66'(cur_tid));
          else begin
            tid_log.push_back(m_tid);
            cur_tid = m_tid;
          end
          in_frame = !m_tlast;
        end
        stall = m_tvalid && !m_tready;
        stall_word = {m_tid, m_tlast, m_tdata};
      end
    end
  end

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (src_a.size() + src_b.size() + exp_a.size() + exp_b.size() == 0 && !m_tvalid) break;
    end
    check("drain", 66'(src_a.size() + src_b.size() + exp_a.size() + exp_b.size()), 66'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frames_a"}, 66'(frames_a), 66'(tot_fr[0]));
    check({tag, "_frames_b"}, 66'(frames_b), 66'(tot_fr[1]));
    check({tag, "_trunc_a"}, 66'(trunc_a), 66'(tot_tr[0]));
    check({tag, "_trunc_b"}, 66'(trunc_b), 66'(tot_tr[1]));
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    m_tready = 1'b1;
    rand_ready = 1'b0;
    gap_pct = 0;
    a_tvalid = 1'b0; a_tlast = 1'b0; a_tdata = '0;
    b_tvalid = 1'b0; b_tlast = 1'b0; b_tdata = '0;
    repeat (3) @(negedge clk);
    check("rst_m_tvalid", 66'(m_tvalid), 66'(0));
    check("rst_a_tready", 66'(a_tready), 66'(0));
    check("rst_b_tready", 66'(b_tready), 66'(0));
    check("rst_m_tdata", 66'(m_tdata), 66'(0));
    check_counters("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fairness: both sources always have 3-beat frames queued.
    for (int i = 0; i < 4; i++) begin
      push_frame(1'b0, 3);
      push_frame(1'b1, 3);
    end
    repeat (2) @(negedge clk);
    enable = 1'b1;
    drain(400);
    check("fair_count", 66'(tid_log.size()), 66'(8));
    for (int i = 0; i < tid_log.size() && i < 8; i++) check("fair_order", 66'(tid_log[i]), 66'(i % 2));
    check_counters("fair");

    // Truncation: 6-beat A frame against MaxBeats=4, B waiting.
    tid_log.delete();
    push_frame(1'b0, 6);
    push_frame(1'b1, 2);
    drain(400);
    check("trunc_count", 66'(tid_log.size()), 66'(2));
    if (tid_log.size() >= 2) check("trunc_next_b", 66'(tid_log[1]), 66'(1));
    check_counters("trunc");

    // Single-beat frames from A alone: one frame per two cycles.
    hs_cyc.delete();
    for (int i = 0; i < 8; i++) push_frame(1'b0, 1);
    drain(400);
    check("single_count", 66'(hs_cyc.size()), 66'(8));
    if (hs_cyc.size() >= 8) check("single_rate", 66'(hs_cyc[7] - hs_cyc[0]), 66'(14));
    check_counters("single");

    // Enable drops after A's first beat; the frame finishes, B waits for enable.
    tid_log.delete();
    push_frame(1'b0, 4);
    for (int i = 0; i < 50 && !(a_tvalid && a_tready); i++) @(negedge clk);
    check("en_a_started", 66'(a_tvalid && a_tready), 66'(1));
    enable = 1'b0;
    push_frame(1'b1, 2);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (b_tready) seen = 1'b1;
    end
    check("en_hold_b", 66'(seen), 66'(0));
    check("en_a_done", 66'(exp_a.size()), 66'(0));
    enable = 1'b1;
    @(negedge clk);
    check("en_regrant", 66'(b_tready), 66'(1));
    drain(400);
    check_counters("enable");

    // Random backpressure and source gaps, 1000 frames of 1..6 beats.
    rand_ready = 1'b1;
    gap_pct = 30;
    for (int i = 0; i < 500; i++) begin
      push_frame(1'b0, int'($urandom_range(1, 6)));
      push_frame(1'b1, int'($urandom_range(1, 6)));
    end
    drain(60000);
    rand_ready = 1'b0;
    gap_pct = 0;
    repeat (3) @(negedge clk);
    check_counters("random");

    // Reset during beat 2 of a B frame.
    push_frame(1'b1, 4);
    for (int i = 0; i < 50 && !(b_tvalid && b_tready); i++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    src_a.delete(); src_b.delete(); exp_a.delete(); exp_b.delete();
    tot_fr[0] = 0; tot_fr[1] = 0; tot_tr[0] = 0; tot_tr[1] = 0;
    #1;
    check("rstmid_m_tvalid", 66'(m_tvalid), 66'(0));
    check("rstmid_b_tready", 66'(b_tready), 66'(0));
    check("rstmid_a_tready", 66'(a_tready), 66'(0));
    check_counters("rstmid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tid_log.delete();
    push_frame(1'b0, 2);
    push_frame(1'b1, 2);
    drain(400);
    check("post_rst_count", 66'(tid_log.size()), 66'(2));
    if (tid_log.size() >= 1) check("post_rst_first_a", 66'(tid_log[0]), 66'(0));
    check_counters("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
